// File: rtl/pipe_reg_pkg.sv
// Shared constants and helpers for the pipe_reg_ctl pipeline register chain.
// No logic; widths for the occupancy output and the optional perf counters.
// No flow control of its own.
package pipe_reg_pkg;

    localparam int PERF_CNT_W = 16;
    localparam logic [PERF_CNT_W-1:0] PERF_CNT_SAT = '1;

    // Bits needed to count 0..stages valid entries; at least one bit.
    function automatic int occ_w(input int stages);
        return (stages < 1) ? 1 : $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One pipeline register stage holding {valid, data}.
// Latency: one cycle from upstream to the stage outputs.
// Backpressure: hold keeps contents; flush/bubble load the BUBBLE payload with valid cleared.
module pipe_reg_stage #(
    parameter int              SIZE   = 32,
    parameter logic [SIZE-1:0] BUBBLE = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush,
    input  logic            hold,
    input  logic            bubble,
    input  logic            up_valid,
    input  logic [SIZE-1:0] up_data,
    output logic            valid,
    output logic [SIZE-1:0] data
);

    // Flush outranks hold so a squashed stage becomes a bubble even while frozen.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            valid <= 1'b0;
            data  <= BUBBLE;
        end else if (hold) begin
            valid <= valid;
            data  <= data;
        end else if (bubble) begin
            valid <= 1'b0;
            data  <= BUBBLE;
        end else begin
            valid <= up_valid;
            data  <= up_data;
        end
    end

endmodule

// File: rtl/pipe_reg_ctl.sv
// Chain of STAGES pipeline registers with per-stage stall/flush; PIPE_REG_CTL_PERF_EN adds stall/bubble counters.
// Latency: STAGES cycles from valid_i/data_i to valid_o/data_o when nothing is held or flushed.
// Backpressure: a stall on stage k freezes stages 0..k (reported on hold_o); the stage below gets bubbles.
module pipe_reg_ctl
    import pipe_reg_pkg::*;
#(
    parameter int              SIZE   = 32,
    parameter int              STAGES = 1,
    parameter logic [SIZE-1:0] BUBBLE = {SIZE{1'b0}}
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [STAGES-1:0]          stall_i,
    input  logic [STAGES-1:0]          flush_i,
    input  logic                       valid_i,
    input  logic [SIZE-1:0]            data_i,
    output logic                       valid_o,
    output logic [SIZE-1:0]            data_o,
    output logic [STAGES-1:0]          hold_o,
    output logic [occ_w(STAGES)-1:0]   occ_o
`ifdef PIPE_REG_CTL_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0]      stall_cnt_o,
    output logic [PERF_CNT_W-1:0]      bubble_cnt_o
`endif
);

    localparam int OCC_W = occ_w(STAGES);

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] valid_q;
    logic [SIZE-1:0]   data_q [STAGES];
    logic [OCC_W-1:0]  occ_sum;

    // A stall anywhere downstream freezes every stage above it.
    always_comb begin
        logic acc;
        acc  = 1'b0;
        hold = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc     = acc | stall_i[k];
            hold[k] = acc;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            pipe_reg_stage #(.SIZE(SIZE), .BUBBLE(BUBBLE)) u_stage (
                .clk_i    (clk_i),
                .rst_i    (rst_i),
                .flush    (flush_i[k]),
                .hold     (hold[k]),
                .bubble   (1'b0),
                .up_valid (valid_i),
                .up_data  (data_i),
                .valid    (valid_q[k]),
                .data     (data_q[k])
            );
        end else begin : g_body
            pipe_reg_stage #(.SIZE(SIZE), .BUBBLE(BUBBLE)) u_stage (
                .clk_i    (clk_i),
                .rst_i    (rst_i),
                .flush    (flush_i[k]),
                .hold     (hold[k]),
                .bubble   (hold[k-1] & ~hold[k]),
                .up_valid (valid_q[k-1]),
                .up_data  (data_q[k-1]),
                .valid    (valid_q[k]),
                .data     (data_q[k])
            );
        end
    end

    always_comb begin
        occ_sum = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_sum = occ_sum + OCC_W'(valid_q[k]);
        end
    end

    assign valid_o = valid_q[STAGES-1];
    assign data_o  = data_q[STAGES-1];
    assign hold_o  = hold;
    assign occ_o   = occ_sum;

`ifdef PIPE_REG_CTL_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (hold[STAGES-1] && (stall_cnt_o != PERF_CNT_SAT)) begin
                stall_cnt_o <= stall_cnt_o + PERF_CNT_W'(1);
            end
            if (!valid_o && (bubble_cnt_o != PERF_CNT_SAT)) begin
                bubble_cnt_o <= bubble_cnt_o + PERF_CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_reg_ctl.sv
// Bench for pipe_reg_ctl (STAGES=3, SIZE=8): directed vector table, then random traffic vs a stage-array model.
module tb_pipe_reg_ctl;

    localparam int         SIZE   = 8;
    localparam int         STAGES = 3;
    localparam logic [7:0] BUB    = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] stall, flush, hold;
    logic       valid_i, valid_o;
    logic [7:0] din, dout;
    logic [1:0] occ;
`ifdef PIPE_REG_CTL_PERF_EN
    logic [15:0] stall_cnt, bubble_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pipe_reg_ctl #(.SIZE(SIZE), .STAGES(STAGES), .BUBBLE(BUB)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .stall_i (stall),
        .flush_i (flush),
        .valid_i (valid_i),
        .data_i  (din),
        .valid_o (valid_o),
        .data_o  (dout),
        .hold_o  (hold),
        .occ_o   (occ)
`ifdef PIPE_REG_CTL_PERF_EN
        ,
        .stall_cnt_o  (stall_cnt),
        .bubble_cnt_o (bubble_cnt)
`endif
    );

    typedef struct {
        logic       rst;
        logic [2:0] stall;
        logic [2:0] flush;
        logic       vin;
        logic [7:0] din;
        logic       ev;
        logic [7:0] ed;
        logic [1:0] eocc;
        logic [2:0] ehold;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic r, input logic [2:0] s, input logic [2:0] f,
                                input logic v, input logic [7:0] d, input logic ev,
                                input logic [7:0] ed, input logic [1:0] eo, input logic [2:0] eh);
        vec_t t;
        t.rst = r; t.stall = s; t.flush = f; t.vin = v; t.din = d;
        t.ev = ev; t.ed = ed; t.eocc = eo; t.ehold = eh;
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic [2:0] s, input logic [2:0] f,
                         input logic v, input logic [7:0] d);
        rst = r; stall = s; flush = f; valid_i = v; din = d;
    endtask

    // Reference: each stage as an array slot, advanced by the stall/flush rules.
    logic       mv[3];
    logic [7:0] md[3];

    initial begin
        //             rst stall   flush   v  din    ev  ed     occ hold
        tbl[0]  = mk(1, 3'b000, 3'b000, 0, 8'h00, 0, BUB,   0, 3'b000); // reset
        tbl[1]  = mk(0, 3'b000, 3'b000, 1, 8'h11, 0, BUB,   1, 3'b000);
        tbl[2]  = mk(0, 3'b000, 3'b000, 1, 8'h22, 0, BUB,   2, 3'b000);
        tbl[3]  = mk(0, 3'b000, 3'b000, 1, 8'h33, 1, 8'h11, 3, 3'b000); // 3-cycle latency
        tbl[4]  = mk(0, 3'b010, 3'b000, 1, 8'h44, 0, BUB,   2, 3'b011); // bubble under stall
        tbl[5]  = mk(0, 3'b010, 3'b000, 1, 8'h44, 0, BUB,   2, 3'b011);
        tbl[6]  = mk(0, 3'b000, 3'b000, 1, 8'h44, 1, 8'h22, 3, 3'b000); // nothing lost
        tbl[7]  = mk(0, 3'b100, 3'b100, 1, 8'h55, 0, BUB,   2, 3'b111); // flush beats hold
        tbl[8]  = mk(0, 3'b100, 3'b000, 1, 8'h55, 0, BUB,   2, 3'b111); // bubble held
        tbl[9]  = mk(0, 3'b000, 3'b000, 1, 8'h55, 1, 8'h33, 3, 3'b000);
        tbl[10] = mk(0, 3'b000, 3'b011, 0, 8'h00, 1, 8'h44, 1, 3'b000); // flush upper stages
        tbl[11] = mk(0, 3'b000, 3'b000, 0, 8'h00, 0, BUB,   0, 3'b000);
        tbl[12] = mk(0, 3'b000, 3'b000, 0, 8'h00, 0, BUB,   0, 3'b000);
        tbl[13] = mk(0, 3'b000, 3'b000, 1, 8'h66, 0, 8'h00, 1, 3'b000); // invalid payload passes through
        tbl[14] = mk(0, 3'b000, 3'b000, 1, 8'h77, 0, 8'h00, 2, 3'b000);
        tbl[15] = mk(1, 3'b111, 3'b101, 1, 8'h88, 0, BUB,   0, 3'b111); // reset beats stall/flush
        tbl[16] = mk(0, 3'b000, 3'b000, 0, 8'h00, 0, BUB,   0, 3'b000);

        drive(1'b1, 3'b000, 3'b000, 1'b0, 8'h00);
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].vin, tbl[i].din);
            @(posedge clk);
            #1;
            check($sformatf("row%0d valid_o", i), int'(valid_o), int'(tbl[i].ev));
            check($sformatf("row%0d data_o", i),  int'(dout),    int'(tbl[i].ed));
            check($sformatf("row%0d occ_o", i),   int'(occ),     int'(tbl[i].eocc));
            check($sformatf("row%0d hold_o", i),  int'(hold),    int'(tbl[i].ehold));
        end

        for (int k = 0; k < 3; k++) begin
            mv[k] = 1'b0;
            md[k] = BUB;
        end

        for (int c = 0; c < 3000; c++) begin
            logic       r, v;
            logic [2:0] s, f, eh;
            logic [7:0] d;
            logic       nv[3];
            logic [7:0] nd[3];
            int         cnt;

            r = (c == 0) || ($urandom_range(0, 63) == 0);
            s = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            f = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            v = 1'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));

            cnt = 0;
            for (int k = 0; k < 3; k++) begin
                logic held, up_held;
                held    = (s >> k) != 3'b000;
                up_held = (k > 0) && ((s >> (k - 1)) != 3'b000);
                eh[k]   = held;
                if (r || f[k]) begin
                    nv[k] = 1'b0; nd[k] = BUB;
                end else if (held) begin
                    nv[k] = mv[k]; nd[k] = md[k];
                end else if (up_held) begin
                    nv[k] = 1'b0; nd[k] = BUB;
                end else if (k == 0) begin
                    nv[k] = v; nd[k] = d;
                end else begin
                    nv[k] = mv[k-1]; nd[k] = md[k-1];
                end
                cnt += int'(nv[k]);
            end

            drive(r, s, f, v, d);
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d valid_o", c), int'(valid_o), int'(nv[2]));
            check($sformatf("rnd%0d data_o", c),  int'(dout),    int'(nd[2]));
            check($sformatf("rnd%0d occ_o", c),   int'(occ),     cnt);
            check($sformatf("rnd%0d hold_o", c),  int'(hold),    int'(eh));

            for (int k = 0; k < 3; k++) begin
                mv[k] = nv[k];
                md[k] = nd[k];
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
